// File: rtl/bch_encoder.sv
// Serial systematic BCH(15,7,t=2) encoder: an LFSR over g(x) = x^8+x^7+x^6+x^4+1
// produces 8 parity bits in 7 cycles, and the result is presented as {msg, parity}.
module bch_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  msg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] codeword
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [6:0]  msg_sr;
    logic [6:0]  msg_hold;
    logic [7:0]  par;
    logic [7:0]  par_next;
    logic [2:0]  cnt;
    logic        accept;
    logic        fb;

    // A finished word can be replaced in the same cycle it is handed off.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign fb       = msg_sr[6] ^ par[7];
    assign par_next = {par[6:0], 1'b0} ^ (fb ? 8'hD1 : 8'h00);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 3'd6) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // msg_hold keeps the systematic part, since msg_sr is consumed by shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_sr   <= 7'h00;
            msg_hold <= 7'h00;
            par      <= 8'h00;
            cnt      <= 3'd0;
            codeword <= 15'h0000;
        end else if (accept) begin
            msg_sr   <= msg;
            msg_hold <= msg;
            par      <= 8'h00;
            cnt      <= 3'd0;
        end else if (state == SHIFT) begin
            msg_sr <= {msg_sr[5:0], 1'b0};
            par    <= par_next;
            cnt    <= cnt + 3'd1;
            if (cnt == 3'd6) begin
                codeword <= {msg_hold, par_next};
            end
        end
    end

endmodule

// File: tb/tb_bch_encoder.sv
// Directed bench for bch_encoder: known vectors, latency, backpressure,
// back-to-back transfers, asynchronous reset and a sweep of all 128 messages.
module tb_bch_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  msg = 7'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] codeword;

    int total = 0;
    int bad = 0;

    bch_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg       (msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeword  (codeword)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Long division of a 15-bit polynomial by g(x); remainder is the low 8 bits.
    function automatic logic [7:0] poly_rem(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (15'h01D1 << (i - 8));
        end
        return r[7:0];
    endfunction

    // Offer m until accepted, then count edges after acceptance until out_valid.
    task automatic applyStimulus(input logic [6:0] m, output int latency);
        int n;
        n = 0;
        msg = m;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        latency = 0;
        while (!out_valid && latency < 40) begin
            step();
            latency++;
        end
    endtask

    logic [6:0]  vec_msg [4] = '{7'h01, 7'h40, 7'h7F, 7'h00};
    logic [14:0] vec_cw  [4] = '{15'h01D1, 15'h40E8, 15'h7FFF, 15'h0000};

    initial begin
        int lat;
        int gap;
        int seen;
        int stall;
        logic [14:0] exp_cw;

        #1;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_codeword", {17'd0, codeword}, 32'h0000);
        step();
        rst = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vec_msg[v], lat);
            checkOutput($sformatf("vec%0d_latency", v), lat, 32'd7);
            checkOutput($sformatf("vec%0d_codeword", v), {17'd0, codeword}, {17'd0, vec_cw[v]});
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checkOutput($sformatf("vec%0d_drained", v), {31'd0, out_valid}, 32'd0);
        end

        applyStimulus(7'h01, lat);
        checkOutput("bp_latency", lat, 32'd7);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            msg = 7'h55;
            step();
            checkOutput("bp_codeword", {17'd0, codeword}, 32'h01D1);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("bp_release", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        checkOutput("bp_single_transfer", seen, 32'd0);

        out_ready = 1'b1;
        msg = 7'h40;
        in_valid = 1'b1;
        step();
        msg = 7'h7F;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        checkOutput("b2b_first_latency", lat, 32'd7);
        checkOutput("b2b_first_codeword", {17'd0, codeword}, 32'h40E8);
        checkOutput("b2b_in_ready_done", {31'd0, in_ready}, 32'd1);
        step();
        gap = 1;
        while (!out_valid && gap < 40) begin
            step();
            gap++;
        end
        checkOutput("b2b_gap", gap, 32'd8);
        checkOutput("b2b_second_codeword", {17'd0, codeword}, 32'h7FFF);
        in_valid = 1'b0;
        step();
        checkOutput("b2b_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        msg = 7'h7F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_shift_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_shift_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_shift_codeword", {17'd0, codeword}, 32'h0000);
        step();
        rst = 1'b1;
        step();
        applyStimulus(7'h40, lat);
        checkOutput("rst_done_pre_codeword", {17'd0, codeword}, 32'h40E8);
        rst = 1'b0;
        #1;
        checkOutput("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_done_codeword", {17'd0, codeword}, 32'h0000);
        checkOutput("rst_done_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        checkOutput("rst_no_output", seen, 32'd0);

        for (int m = 0; m < 128; m++) begin
            repeat ($urandom_range(0, 3)) step();
            out_ready = 1'($urandom_range(0, 1));
            applyStimulus(7'(m), lat);
            exp_cw = {7'(m), poly_rem({7'(m), 8'h00})};
            checkOutput($sformatf("sweep_%0h_codeword", m), {17'd0, codeword}, {17'd0, exp_cw});
            checkOutput($sformatf("sweep_%0h_syndrome", m), {24'd0, poly_rem(codeword)}, 32'd0);
            if (lat != 7) checkOutput($sformatf("sweep_%0h_latency", m), lat, 32'd7);
            out_ready = 1'b0;
            stall = $urandom_range(0, 3);
            repeat (stall) step();
            if (stall > 0) checkOutput($sformatf("sweep_%0h_stable", m), {17'd0, codeword}, {17'd0, exp_cw});
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checkOutput($sformatf("sweep_%0h_drained", m), {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
